warmboot_ctrl: RTL and testbench
================================

# warmboot_ctrl

Parametrised warm-boot controller for iCE40 boards with multi-image flash. It debounces up to four user keys and accepts a software boot request from the bootloader core. It resolves these into one image selection and drives the `SB_WARMBOOT` S1/S0/BOOT inputs with correct setup ordering. An optional LED blink code identifies the chosen image before reconfiguration. It sits in the board top level between the bootloader instance, the key pins and the warmboot primitive, in place of the direct `boot | key` OR.

## Interface
- `NUM_KEYS`, 1: number of key inputs, range 1..4. Key k requests image k.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required to change a debounced key state, ≥2.
- `LONG_PRESS_CYCLES`, 24000000: hold time that turns any press into a bootloader (image 0) request.
- `BLINK_CYCLES`, 1200000: LED on-time and off-time per blink.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `key`  in  NUM_KEYS  raw asynchronous key pins, active-high
- `boot_req`  in  1  software boot request pulse from the bootloader core
- `boot_sel`  in  2  image to boot, sampled with `boot_req`
- `led_in`  in  1  normal LED drive, passed through when idle
- `wb_s1`  out  1  to SB_WARMBOOT S1
- `wb_s0`  out  1  to SB_WARMBOOT S0
- `wb_boot`  out  1  to SB_WARMBOOT BOOT
- `led`  out  1  LED pin drive
- `busy`  out  1  selection latched; boot in progress

## Operation
- Each key passes through a 2-flop synchroniser and then a per-key debounce counter. The debounced state toggles only after DEBOUNCE_CYCLES consecutive cycles of a synchronised value that differs from the current state. Any glitch resets the counter.
- A hold counter runs while any debounced key is high in IDLE.
- States:
  - IDLE: `led = led_in`.
    - `boot_req` = 1 → SETUP with image = `boot_sel`.
    - A debounced key falling edge with hold < LONG_PRESS_CYCLES → SETUP with image = lowest-index key released that cycle.
    - Hold reaching LONG_PRESS_CYCLES → SETUP with image 0. No release is needed.
  - SETUP: register `{wb_s1, wb_s0}` = image and set `busy` = 1. Go to INDICATE if compiled in, else FIRE.
  - INDICATE: blink `led` image+1 times, each blink BLINK_CYCLES high then BLINK_CYCLES low. Then FIRE.
  - FIRE: `wb_boot` = 1, held until reset. `led` = 1.
- Priority: `boot_req` wins over any key event in the same cycle. Among simultaneous key releases, the lowest index wins.
- Once out of IDLE, all later `boot_req` and key activity is ignored.
- `wb_s1` and `wb_s0` are stable for ≥1 cycle before `wb_boot` rises and never change while `wb_boot` = 1.

## Timing
- Reset values:
  - `wb_s1 = wb_s0 = wb_boot = busy = 0`
  - state IDLE
  - debounced keys 0; all counters 0
  - `led` follows `led_in` combinationally from the first post-reset cycle
- Key latency: press at the pin to debounced high = 2 + DEBOUNCE_CYCLES cycles. The release edge adds the same delay.
- `boot_req` sampled at cycle N:
  - SETUP at N+1, so S bits and `busy` are visible at N+2.
  - Without INDICATE: `wb_boot` = 1 at N+3.
  - With INDICATE: `wb_boot` = 1 at N+3+2·(image+1)·BLINK_CYCLES.
- Counters saturate: the hold counter stops at LONG_PRESS_CYCLES, so no wrap-around. Widths are `$clog2(param+1)`.
- Long-press threshold: the cycle the counter equals LONG_PRESS_CYCLES − 1 with the key still high fires the image-0 request. A release on that same cycle counts as a long press.
- Reset mid-operation (SETUP/INDICATE/FIRE) returns to IDLE with all outputs at reset values the next cycle. A warmboot already triggered in silicon is not reversible.
- `boot_sel` values ≥ 4 are not possible (2 bits). Key indices ≥ NUM_KEYS do not exist.

## Configuration
- `WARMBOOT_INDICATE_EN` defined: the INDICATE state and blink counters are compiled in, and SETUP → INDICATE → FIRE.
- Not defined: no INDICATE logic, SETUP → FIRE directly, `led` = `led_in` in SETUP and 1 in FIRE, and BLINK_CYCLES is unused.

## Test plan
- Test parameters: NUM_KEYS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50, BLINK_CYCLES=3.
- `boot_req` = 1 with `boot_sel` = 2'b10 at cycle 10, INDICATE off → `wb_s1`=1, `wb_s0`=0, `busy`=1 at cycle 12, and `wb_boot`=1 at cycle 13 and stays 1.
- Same stimulus with INDICATE on → `led` shows 3 pulses of 3 high / 3 low cycles, `wb_boot` rises at cycle 31, and S bits are unchanged throughout.
- `key[1]` bounces 0/1 every 2 cycles for 20 cycles, then is held high for 10 cycles and released → no state change during the bounce, then SETUP with image 1 after the debounced release.
- `key[0]` held 60 cycles → image-0 SETUP fires while the key is still held. The later release is ignored and `wb_s1`=`wb_s0`=0.
- `boot_req` (`boot_sel`=3) and the debounced `key[1]` falling edge in the same cycle → image 3 selected.
- Reset asserted 2 cycles into INDICATE → next cycle: all outputs 0, `led` = `led_in`, and a fresh `boot_req` is accepted again.

Source files
------------

// File: rtl/warmboot_ctrl_if.sv
// Boot request and SB_WARMBOOT select/trigger bundle between bootloader, controller and primitive.
interface warmboot_ctrl_if;
  logic       boot_req;
  logic [1:0] boot_sel;
  logic       wb_s1;
  logic       wb_s0;
  logic       wb_boot;
  logic       busy;

  modport master (
    output boot_req, boot_sel,
    input  wb_s1, wb_s0, wb_boot, busy
  );

  modport slave (
    input  boot_req, boot_sel,
    output wb_s1, wb_s0, wb_boot, busy
  );
endinterface

// File: rtl/warmboot_ctrl.sv
// Warm-boot controller: debounced keys + software request -> SB_WARMBOOT image select and trigger.
// Optional LED blink code of the chosen image is compiled in with WARMBOOT_INDICATE_EN.
module warmboot_ctrl #(
  parameter int unsigned NUM_KEYS          = 1,
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 24000000,
  parameter int unsigned BLINK_CYCLES      = 1200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                led_in,
  output logic                led,
  warmboot_ctrl_if.slave      wb_if
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETUP    = 2'd1;
  localparam logic [1:0] ST_FIRE     = 2'd2;
`ifdef WARMBOOT_INDICATE_EN
  localparam logic [1:0] ST_INDICATE = 2'd3;
`endif

  if (NUM_KEYS < 1 || NUM_KEYS > 4) begin : g_bad_num_keys
    $error("warmboot_ctrl: NUM_KEYS must be 1..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("warmboot_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
    $error("warmboot_ctrl: LONG_PRESS_CYCLES must be >= 1");
  end
  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("warmboot_ctrl: BLINK_CYCLES must be >= 1");
  end

  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] key_s2;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] deb_d;
  logic [NUM_KEYS-1:0] fall_c;
  logic [HOLD_W-1:0]   hold;
  logic                long_c;
  logic [1:0]          key_img_c;

  logic [1:0] state, state_d;
  logic [1:0] img, img_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       boot_q, boot_d;

  // Two-flop synchroniser on the raw key pins
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // Per-key debounce: state flips only after DEBOUNCE_CYCLES differing samples in a row
  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_deb
    logic [DB_W-1:0] cnt;
    logic            deb_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        deb_q <= 1'b0;
      end else if (key_s2[k] == deb_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        deb_q <= key_s2[k];
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign deb[k] = deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) deb_d <= '0;
    else       deb_d <= deb;
  end

  assign fall_c = deb_d & ~deb;

  // Hold timer only matters in IDLE; it saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
    end else if (state == ST_IDLE && |deb) begin
      if (hold != HOLD_MAX) hold <= hold + HOLD_W'(1);
    end else begin
      hold <= '0;
    end
  end

  assign long_c = (hold == HOLD_LAST);

  always_comb begin
    logic found;
    found     = 1'b0;
    key_img_c = 2'd0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (fall_c[i] && !found) begin
        found     = 1'b1;
        key_img_c = 2'(i);
      end
    end
  end

`ifdef WARMBOOT_INDICATE_EN
  localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  logic [BL_W-1:0] blink_cnt, blink_cnt_d;
  logic            blink_on, blink_on_d;
  logic [1:0]      blink_left, blink_left_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      img    <= 2'd0;
      sel_q  <= 2'd0;
      busy_q <= 1'b0;
      boot_q <= 1'b0;
`ifdef WARMBOOT_INDICATE_EN
      blink_cnt  <= '0;
      blink_on   <= 1'b0;
      blink_left <= 2'd0;
`endif
    end else begin
      state  <= state_d;
      img    <= img_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
      boot_q <= boot_d;
`ifdef WARMBOOT_INDICATE_EN
      blink_cnt  <= blink_cnt_d;
      blink_on   <= blink_on_d;
      blink_left <= blink_left_d;
`endif
    end
  end

  // Request arbitration and boot sequencing; S bits are set one state before BOOT
  always_comb begin
    state_d = state;
    img_d   = img;
    sel_d   = sel_q;
    busy_d  = busy_q;
    boot_d  = boot_q;
`ifdef WARMBOOT_INDICATE_EN
    blink_cnt_d  = blink_cnt;
    blink_on_d   = blink_on;
    blink_left_d = blink_left;
`endif
    case (state)
      ST_IDLE: begin
        if (wb_if.boot_req) begin
          img_d   = wb_if.boot_sel;
          state_d = ST_SETUP;
        end else if (long_c) begin
          img_d   = 2'd0;
          state_d = ST_SETUP;
        end else if (|fall_c) begin
          img_d   = key_img_c;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sel_d  = img;
        busy_d = 1'b1;
`ifdef WARMBOOT_INDICATE_EN
        blink_cnt_d  = '0;
        blink_on_d   = 1'b1;
        blink_left_d = img;
        state_d      = ST_INDICATE;
`else
        state_d = ST_FIRE;
`endif
      end
`ifdef WARMBOOT_INDICATE_EN
      ST_INDICATE: begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt_d = '0;
          if (blink_on) begin
            blink_on_d = 1'b0;
          end else if (blink_left == 2'd0) begin
            state_d = ST_FIRE;
          end else begin
            blink_left_d = blink_left - 2'd1;
            blink_on_d   = 1'b1;
          end
        end else begin
          blink_cnt_d = blink_cnt + BL_W'(1);
        end
      end
`endif
      ST_FIRE: begin
        boot_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    led = led_in;
    case (state)
      ST_FIRE:     led = 1'b1;
`ifdef WARMBOOT_INDICATE_EN
      ST_INDICATE: led = blink_on;
`endif
      default:     led = led_in;
    endcase
  end

  assign wb_if.wb_s1   = sel_q[1];
  assign wb_if.wb_s0   = sel_q[0];
  assign wb_if.wb_boot = boot_q;
  assign wb_if.busy    = busy_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Testbench for warmboot_ctrl: directed scenarios plus randomized key/request traffic against a cycle model.
module tb_warmboot_ctrl;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int LP = 50;
  localparam int BL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key;
  logic          led_in;
  logic          led;

  warmboot_ctrl_if bus ();

  warmboot_ctrl #(
    .NUM_KEYS          (NK),
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .BLINK_CYCLES      (BL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key    (key),
    .led_in (led_in),
    .led    (led),
    .wb_if  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract commit event (cycle + image) and per-key sample histories
  bit          m_valid = 1'b0;
  bit          m_commit;
  int          m_t = 0;
  int          m_n;
  bit [1:0]    m_img;
  bit [NK-1:0] raw_d1, raw_d2;
  bit [NK-1:0] shist [DB];
  bit [NK-1:0] m_deb, m_deb_prev;
  int          m_run;

  always @(negedge clk) begin
    int          k, j, len;
    logic [3:0]  e_s1, e_s0, e_busy, e_boot, e_led;
    bit [NK-1:0] fall, ndeb;
    bit          idle_now, flip, found;

    if (m_valid) begin
      k = m_t - m_n;
      if (!m_commit || k <= 1) begin
        e_s1 = 0; e_s0 = 0; e_busy = 0; e_boot = 0; e_led = {3'b0, led_in};
      end else begin
        e_s1 = {3'b0, m_img[1]};
        e_s0 = {3'b0, m_img[0]};
        e_busy = 1;
`ifdef WARMBOOT_INDICATE_EN
        j   = k - 2;
        len = 2 * (int'(m_img) + 1) * BL;
        if (j < len) begin
          e_led  = ((j / BL) % 2 == 0) ? 4'd1 : 4'd0;
          e_boot = 0;
        end else begin
          e_led  = 1;
          e_boot = (j > len) ? 4'd1 : 4'd0;
        end
`else
        e_led  = 1;
        e_boot = (k >= 3) ? 4'd1 : 4'd0;
`endif
      end
      chk("wb_s1",   {3'b0, bus.wb_s1},   e_s1);
      chk("wb_s0",   {3'b0, bus.wb_s0},   e_s0);
      chk("busy",    {3'b0, bus.busy},    e_busy);
      chk("wb_boot", {3'b0, bus.wb_boot}, e_boot);
      chk("led",     {3'b0, led},         e_led);
    end

    if (reset) begin
      m_valid    = 1'b1;
      m_commit   = 1'b0;
      m_run      = 0;
      raw_d1     = '0;
      raw_d2     = '0;
      m_deb      = '0;
      m_deb_prev = '0;
      for (int i = 0; i < DB; i++) shist[i] = '0;
    end else if (m_valid) begin
      idle_now = !m_commit;
      fall     = m_deb_prev & ~m_deb;
      if (idle_now) begin
        if (bus.boot_req) begin
          m_commit = 1'b1; m_n = m_t; m_img = bus.boot_sel;
        end else if (m_run == LP - 1) begin
          m_commit = 1'b1; m_n = m_t; m_img = 2'd0;
        end else if (fall != '0) begin
          found = 1'b0;
          for (int i = 0; i < NK; i++) begin
            if (fall[i] && !found) begin
              found = 1'b1;
              m_img = 2'(i);
            end
          end
          m_commit = 1'b1; m_n = m_t;
        end
      end
      m_run = (idle_now && m_deb != '0) ? ((m_run < LP) ? m_run + 1 : LP) : 0;
      for (int i = 0; i < DB - 1; i++) shist[i] = shist[i+1];
      shist[DB-1] = raw_d2;
      for (int q = 0; q < NK; q++) begin
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (shist[i][q] == m_deb[q]) flip = 1'b0;
        ndeb[q] = flip ? ~m_deb[q] : m_deb[q];
      end
      m_deb_prev = m_deb;
      m_deb      = ndeb;
      raw_d2     = raw_d1;
      raw_d1     = key;
    end
    m_t++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    led_in = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.boot_req = 1'b0;
    key          = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int div;
    reset        = 1'b1;
    key          = '0;
    led_in       = 1'b0;
    bus.boot_req = 1'b0;
    bus.boot_sel = 2'd0;

    // Software request, image 2
    do_reset();
    repeat (3) tick();
    bus.boot_req = 1'b1;
    bus.boot_sel = 2'd2;
    tick();
    bus.boot_req = 1'b0;
    bus.boot_sel = 2'd0;
    #1 chk("setup_busy_low", {3'b0, bus.busy}, 4'd0);
    tick();
    #1;
    chk("sel_s1", {3'b0, bus.wb_s1}, 4'd1);
    chk("sel_s0", {3'b0, bus.wb_s0}, 4'd0);
    chk("sel_busy", {3'b0, bus.busy}, 4'd1);
    chk("sel_boot_low", {3'b0, bus.wb_boot}, 4'd0);
    tick();
`ifdef WARMBOOT_INDICATE_EN
    #1 chk("ind_boot_n3", {3'b0, bus.wb_boot}, 4'd0);
    chk("ind_led_on", {3'b0, led}, 4'd1);
    repeat (3) tick();
    #1 chk("ind_led_off", {3'b0, led}, 4'd0);
    repeat (14) tick();
    #1 chk("ind_boot_n20", {3'b0, bus.wb_boot}, 4'd0);
    tick();
    #1 chk("ind_boot_n21", {3'b0, bus.wb_boot}, 4'd1);
`else
    #1 chk("boot_n3", {3'b0, bus.wb_boot}, 4'd1);
`endif
    for (int i = 0; i < 12; i++) begin
      bus.boot_req = 1'($urandom_range(0, 1));
      bus.boot_sel = 2'($urandom_range(0, 3));
      key          = NK'($urandom_range(0, 3));
      tick();
    end
    bus.boot_req = 1'b0;
    #1 chk("ignored_s1", {3'b0, bus.wb_s1}, 4'd1);
    chk("ignored_s0", {3'b0, bus.wb_s0}, 4'd0);

    // Bouncing key 1, then a clean short press
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key[1] = 1'((i / 2) % 2);
      tick();
    end
    #1 chk("bounce_idle", {3'b0, bus.busy}, 4'd0);
    key[1] = 1'b1;
    repeat (10) tick();
    key[1] = 1'b0;
    repeat (12) tick();
    #1 chk("key1_img", {2'b0, bus.wb_s1, bus.wb_s0}, 4'd1);
    chk("key1_busy", {3'b0, bus.busy}, 4'd1);

    // Long press on key 0 fires before release
    do_reset();
    key[0] = 1'b1;
    repeat (60) tick();
    #1 chk("long_busy_held", {3'b0, bus.busy}, 4'd1);
    chk("long_img_held", {2'b0, bus.wb_s1, bus.wb_s0}, 4'd0);
    key[0] = 1'b0;
    repeat (40) tick();
    #1 chk("long_img_after", {2'b0, bus.wb_s1, bus.wb_s0}, 4'd0);
    chk("long_boot", {3'b0, bus.wb_boot}, 4'd1);

    // boot_req coincident with debounced key 1 release
    do_reset();
    key[1] = 1'b1;
    repeat (10) tick();
    key[1] = 1'b0;
    repeat (6) tick();
    bus.boot_req = 1'b1;
    bus.boot_sel = 2'd3;
    tick();
    bus.boot_req = 1'b0;
    tick();
    #1 chk("prio_img", {2'b0, bus.wb_s1, bus.wb_s0}, 4'd3);

    // Reset two cycles into the blink sequence, then a fresh request
    do_reset();
    tick();
    bus.boot_req = 1'b1;
    bus.boot_sel = 2'd2;
    tick();
    bus.boot_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_s", {2'b0, bus.wb_s1, bus.wb_s0}, 4'd0);
    chk("rst_busy", {3'b0, bus.busy}, 4'd0);
    chk("rst_boot", {3'b0, bus.wb_boot}, 4'd0);
    chk("rst_led", {3'b0, led}, {3'b0, led_in});
    bus.boot_req = 1'b1;
    bus.boot_sel = 2'd1;
    tick();
    bus.boot_req = 1'b0;
    tick();
    #1 chk("rst_fresh_img", {2'b0, bus.wb_s1, bus.wb_s0}, 4'd1);

    // Randomized key and request traffic
    for (int ep = 0; ep < 24; ep++) begin
      do_reset();
      case (ep % 3)
        0:       div = 4;
        1:       div = 16;
        default: div = 64;
      endcase
      for (int c = 0; c < 160; c++) begin
        for (int q = 0; q < NK; q++)
          if ($urandom_range(0, div - 1) == 0) key[q] = ~key[q];
        bus.boot_req = ($urandom_range(0, 99) == 0);
        bus.boot_sel = 2'($urandom_range(0, 3));
        tick();
      end
    end

    bus.boot_req = 1'b0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
